// File: rtl/pipeline_hazard_ctrl.sv
// Hazard sequencer for a 5-stage pipeline.
// Combines load-use stalls, branch/jump squashes and data-memory wait
// freezes into per-register enable/flush strobes. It also selects the
// EX-stage forwarding sources, and traps a memory that never answers.
module pipeline_hazard_ctrl #(
    parameter int REG_W   = 5,
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_uses_rt,
    input  logic             id_jump,
    input  logic             ex_mem_read,
    input  logic [REG_W-1:0] ex_rd,
    input  logic [REG_W-1:0] ex_rs,
    input  logic [REG_W-1:0] ex_rt,
    input  logic             ex_branch_taken,
    input  logic [REG_W-1:0] mem_rd,
    input  logic             mem_reg_write,
    input  logic             mem_access,
    input  logic             mem_ready,
    input  logic [REG_W-1:0] wb_rd,
    input  logic             wb_reg_write,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             ifid_flush,
    output logic             idex_en,
    output logic             idex_flush,
    output logic             exmem_en,
    output logic             memwb_bubble,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] stall_count
);

    localparam int WC_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {RUN, MEM_WAIT, FAULT} state_t;

    state_t            state_reg, state_next;
    logic [WC_W-1:0]   wait_cnt_reg, wait_cnt_next;
    logic [CNT_W-1:0]  stall_cnt_reg;
    logic              memstall;
    logic              loaduse;
    logic              stall_win;

    assign memstall = mem_access & ~mem_ready;
    assign loaduse  = ex_mem_read & (ex_rd != '0) &
                      ((ex_rd == id_rs) | (id_uses_rt & (ex_rd == id_rt)));

    // State and wait counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= RUN;
            wait_cnt_reg <= '0;
        end else begin
            state_reg    <= state_next;
            wait_cnt_reg <= wait_cnt_next;
        end
    end

    // Next state: count consecutive not-ready cycles, trap after TIMEOUT of them.
    always_comb begin
        state_next    = state_reg;
        wait_cnt_next = wait_cnt_reg;
        case (state_reg)
            RUN: begin
                if (memstall) begin
                    state_next    = MEM_WAIT;
                    wait_cnt_next = WC_W'(1);
                end
            end
            MEM_WAIT: begin
                if (memstall) begin
                    if (wait_cnt_reg == WC_W'(TIMEOUT - 1))
                        state_next = FAULT;
                    else
                        wait_cnt_next = wait_cnt_reg + 1'b1;
                end else begin
                    state_next    = RUN;
                    wait_cnt_next = '0;
                end
            end
            FAULT:   state_next = FAULT;
            default: state_next = RUN;
        endcase
    end

    // Pipeline strobes, resolved by priority within the current cycle.
    // The safe "everything frozen, bubble into WB" pattern is the default,
    // shared by reset, FAULT and memory stalls.
    always_comb begin
        pc_en        = 1'b0;
        ifid_en      = 1'b0;
        ifid_flush   = 1'b0;
        idex_en      = 1'b0;
        idex_flush   = 1'b0;
        exmem_en     = 1'b0;
        memwb_bubble = 1'b1;
        mem_timeout  = 1'b0;
        stall_win    = 1'b0;
        if (!rst_n) begin
            mem_timeout = 1'b0;
        end else if (state_reg == FAULT) begin
            mem_timeout = 1'b1;
        end else if (memstall) begin
            stall_win = 1'b1;
        end else begin
            pc_en        = 1'b1;
            ifid_en      = 1'b1;
            idex_en      = 1'b1;
            exmem_en     = 1'b1;
            memwb_bubble = 1'b0;
            if (ex_branch_taken) begin
                ifid_flush = 1'b1;
                idex_flush = 1'b1;
            end else if (loaduse) begin
                // Hold PC and IF/ID, insert one bubble behind the load.
                pc_en      = 1'b0;
                ifid_en    = 1'b0;
                idex_flush = 1'b1;
                stall_win  = 1'b1;
            end else if (id_jump) begin
                ifid_flush = 1'b1;
            end
        end
    end

    // Saturating count of cycles lost to memory waits and load-use stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            stall_cnt_reg <= '0;
        else if (stall_win && (stall_cnt_reg != '1))
            stall_cnt_reg <= stall_cnt_reg + 1'b1;
    end

    assign stall_count = stall_cnt_reg;

    // Forwarding selects for both EX operands; EX/MEM beats MEM/WB.
    logic [REG_W-1:0] ex_src [2];
    logic [1:0]       fwd_sel [2];

    assign ex_src[0] = ex_rs;
    assign ex_src[1] = ex_rt;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_fwd
            // Operand source select, forced to register file during reset.
            always_comb begin
                fwd_sel[gi] = 2'b00;
                if (rst_n) begin
                    if (mem_reg_write && (mem_rd != '0) && (mem_rd == ex_src[gi]))
                        fwd_sel[gi] = 2'b10;
                    else if (wb_reg_write && (wb_rd != '0) && (wb_rd == ex_src[gi]))
                        fwd_sel[gi] = 2'b01;
                end
            end
        end
    endgenerate

    assign fwd_a = fwd_sel[0];
    assign fwd_b = fwd_sel[1];

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl. The driver applies one vector per
// cycle just after the rising edge and queues the hand-derived response; the
// monitor pops and compares on the falling edge.
module tb_pipeline_hazard_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [4:0]  id_rs, id_rt, ex_rd, ex_rs, ex_rt, mem_rd, wb_rd;
    logic        id_uses_rt, id_jump, ex_mem_read, ex_branch_taken;
    logic        mem_reg_write, mem_access, mem_ready, wb_reg_write;
    logic        pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, memwb_bubble;
    logic [1:0]  fwd_a, fwd_b;
    logic        mem_timeout;
    logic [15:0] stall_count;

    // Strobe order: {pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, memwb_bubble}
    localparam logic [6:0] S_RUN = 7'b1101010;
    localparam logic [6:0] S_LU  = 7'b0001110;
    localparam logic [6:0] S_BR  = 7'b1111110;
    localparam logic [6:0] S_JP  = 7'b1111010;
    localparam logic [6:0] S_FRZ = 7'b0000001;

    typedef struct {
        string       name;
        logic [6:0]  strb;
        logic [1:0]  fa;
        logic [1:0]  fb;
        logic        to;
        logic [15:0] sc;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;
    bit   done     = 1'b0;

    pipeline_hazard_ctrl #(.REG_W(5), .TIMEOUT(16), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt), .id_jump(id_jump),
        .ex_mem_read(ex_mem_read), .ex_rd(ex_rd), .ex_rs(ex_rs), .ex_rt(ex_rt),
        .ex_branch_taken(ex_branch_taken),
        .mem_rd(mem_rd), .mem_reg_write(mem_reg_write), .mem_access(mem_access),
        .mem_ready(mem_ready), .wb_rd(wb_rd), .wb_reg_write(wb_reg_write),
        .pc_en(pc_en), .ifid_en(ifid_en), .ifid_flush(ifid_flush), .idex_en(idex_en),
        .idex_flush(idex_flush), .exmem_en(exmem_en), .memwb_bubble(memwb_bubble),
        .fwd_a(fwd_a), .fwd_b(fwd_b), .mem_timeout(mem_timeout), .stall_count(stall_count)
    );

    always #5 clk = ~clk;

    task automatic chk(string n, string what, logic [15:0] got, logic [15:0] req);
        checks++;
        if (got !== req) begin
            failures++;
            $display("FAIL %s.%s got=%h required=%h", n, what, got, req);
        end
    endtask

    // Monitor: one comparison set per queued transaction.
    initial begin
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                exp_t e;
                e = sb.pop_front();
                chk(e.name, "strobes", 16'({pc_en, ifid_en, ifid_flush, idex_en,
                                            idex_flush, exmem_en, memwb_bubble}), 16'(e.strb));
                chk(e.name, "fwd_a", 16'(fwd_a), 16'(e.fa));
                chk(e.name, "fwd_b", 16'(fwd_b), 16'(e.fb));
                chk(e.name, "mem_timeout", 16'(mem_timeout), 16'(e.to));
                chk(e.name, "stall_count", stall_count, e.sc);
                $display("txn %s strobes=%b fwd=%b/%b to=%b sc=%0d",
                         e.name, {pc_en, ifid_en, ifid_flush, idex_en, idex_flush,
                                  exmem_en, memwb_bubble}, fwd_a, fwd_b, mem_timeout, stall_count);
            end
        end
    end

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        id_rs = '0; id_rt = '0; ex_rd = '0; ex_rs = '0; ex_rt = '0; mem_rd = '0; wb_rd = '0;
        id_uses_rt = 0; id_jump = 0; ex_mem_read = 0; ex_branch_taken = 0;
        mem_reg_write = 0; mem_access = 0; mem_ready = 0; wb_reg_write = 0;
    endtask

    task automatic expect_o(string n, logic [6:0] s, logic [1:0] fa, logic [1:0] fb,
                            logic to, logic [15:0] sc);
        exp_t e;
        e.name = n; e.strb = s; e.fa = fa; e.fb = fb; e.to = to; e.sc = sc;
        sb.push_back(e);
    endtask

    // Watchdog so the run always ends.
    initial begin
        #200000;
        if (!done) begin
            $display("FAIL watchdog got=timeout required=finish");
            $fatal(1, "bench timeout");
        end
    end

    initial begin
        rst_n = 1'b0;
        clr();
        nxt(); expect_o("reset", S_FRZ, 2'b00, 2'b00, 0, 0);
        nxt(); rst_n = 1'b1; expect_o("idle", S_RUN, 2'b00, 2'b00, 0, 0);

        // Load-use on rs, then on rt gated by id_uses_rt.
        nxt(); ex_mem_read = 1; ex_rd = 5; id_rs = 5; expect_o("lu_rs", S_LU, 2'b00, 2'b00, 0, 0);
        nxt(); clr(); expect_o("lu_after", S_RUN, 2'b00, 2'b00, 0, 1);
        nxt(); ex_mem_read = 1; ex_rd = 6; id_rt = 6; id_rs = 1;
        expect_o("lu_rt_unused", S_RUN, 2'b00, 2'b00, 0, 1);
        nxt(); id_uses_rt = 1; expect_o("lu_rt", S_LU, 2'b00, 2'b00, 0, 1);
        nxt(); clr(); expect_o("lu_rt_after", S_RUN, 2'b00, 2'b00, 0, 2);

        // Branch beats load-use; rd=0 load is harmless; jump; load-use beats jump.
        nxt(); ex_mem_read = 1; ex_rd = 5; id_rs = 5; ex_branch_taken = 1;
        expect_o("br_over_lu", S_BR, 2'b00, 2'b00, 0, 2);
        nxt(); clr(); ex_mem_read = 1; ex_rd = 0; id_rs = 0;
        expect_o("lu_rd0", S_RUN, 2'b00, 2'b00, 0, 2);
        nxt(); clr(); id_jump = 1; expect_o("jump", S_JP, 2'b00, 2'b00, 0, 2);
        nxt(); ex_mem_read = 1; ex_rd = 9; id_rs = 9;
        expect_o("lu_over_jump", S_LU, 2'b00, 2'b00, 0, 2);
        nxt(); clr(); mem_access = 1; mem_ready = 1;
        expect_o("mem_ready_hit", S_RUN, 2'b00, 2'b00, 0, 3);

        // Three-cycle memory wait with a taken branch held in EX.
        nxt(); mem_ready = 0; ex_branch_taken = 1; expect_o("mw1", S_FRZ, 2'b00, 2'b00, 0, 3);
        nxt(); expect_o("mw2", S_FRZ, 2'b00, 2'b00, 0, 4);
        nxt(); expect_o("mw3", S_FRZ, 2'b00, 2'b00, 0, 5);
        nxt(); mem_ready = 1; expect_o("mw_release_br", S_BR, 2'b00, 2'b00, 0, 6);
        nxt(); clr(); expect_o("post_mw", S_RUN, 2'b00, 2'b00, 0, 6);

        // Forwarding selects.
        nxt(); ex_rs = 7; ex_rt = 7; mem_rd = 7; wb_rd = 7; mem_reg_write = 1; wb_reg_write = 1;
        expect_o("fwd_mem", S_RUN, 2'b10, 2'b10, 0, 6);
        nxt(); mem_reg_write = 0; expect_o("fwd_wb", S_RUN, 2'b01, 2'b01, 0, 6);
        nxt(); mem_reg_write = 1; mem_rd = 0; wb_rd = 0; ex_rs = 0; ex_rt = 0;
        expect_o("fwd_rd0", S_RUN, 2'b00, 2'b00, 0, 6);
        nxt(); ex_rs = 7; ex_rt = 3; mem_rd = 7; wb_rd = 3;
        expect_o("fwd_split", S_RUN, 2'b10, 2'b01, 0, 6);
        nxt(); ex_rs = 2; ex_rt = 7; mem_rd = 7; wb_rd = 7; wb_reg_write = 0;
        expect_o("fwd_b_only", S_RUN, 2'b00, 2'b10, 0, 6);

        // Asynchronous reset in the middle of a memory wait.
        nxt(); clr(); mem_access = 1; expect_o("mw_a", S_FRZ, 2'b00, 2'b00, 0, 6);
        nxt(); ex_rs = 7; mem_rd = 7; mem_reg_write = 1;
        expect_o("mw_b", S_FRZ, 2'b10, 2'b00, 0, 7);
        nxt(); rst_n = 1'b0; expect_o("async_rst", S_FRZ, 2'b00, 2'b00, 0, 0);
        nxt(); rst_n = 1'b1; clr(); expect_o("rst_release", S_RUN, 2'b00, 2'b00, 0, 0);

        // Hung memory: 16 not-ready cycles, then FAULT.
        for (int i = 0; i < 16; i++) begin
            nxt(); mem_access = 1; mem_ready = 0;
            expect_o($sformatf("hang%0d", i + 1), S_FRZ, 2'b00, 2'b00, 0, 16'(i));
        end
        nxt(); expect_o("fault", S_FRZ, 2'b00, 2'b00, 1, 16);
        nxt(); clr(); mem_ready = 1; ex_branch_taken = 1; ex_rs = 7; mem_rd = 7; mem_reg_write = 1;
        expect_o("fault_sticky", S_FRZ, 2'b10, 2'b00, 1, 16);
        nxt(); rst_n = 1'b0; expect_o("fault_rst", S_FRZ, 2'b00, 2'b00, 0, 0);
        nxt(); rst_n = 1'b1; clr(); expect_o("fault_cleared", S_RUN, 2'b00, 2'b00, 0, 0);
        nxt(); ex_mem_read = 1; ex_rd = 4; id_rs = 4; expect_o("lu_final", S_LU, 2'b00, 2'b00, 0, 0);
        nxt(); clr(); expect_o("end", S_RUN, 2'b00, 2'b00, 0, 1);

        // Let the monitor drain, bounded.
        for (int i = 0; i < 4 && sb.size() > 0; i++) @(negedge clk);
        #1;
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL drain got=%0d required=0", sb.size());
        end
        done = 1'b1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
